// File: rtl/mult_rr_sched.sv
// ============================================================================
// mult_rr_sched
// ----------------------------------------------------------------------------
// Purpose
//   Shares one combinational 4x4 -> 8 unsigned multiplier (combo_mult) between
//   NUM_REQ requesters. A round-robin arbiter picks one request at a time. The
//   operands are registered on acceptance and the product is registered one
//   cycle later, so the multiplier always sits between two flops.
//   The sequence is IDLE -> MUL -> RESP -> IDLE, which gives a minimum issue
//   interval of three cycles.
//
// Parameters
//   NUM_REQ   number of requesters (2..8)
//   CNT_W     width of the completed-operation counter
//
// Ports
//   clk         in   1            rising-edge clock
//   rst         in   1            synchronous active-high reset
//   req_valid   in   NUM_REQ      requester i has operands pending
//   req_a       in   4*NUM_REQ    operand A of requester i at [4i+:4]
//   req_b       in   4*NUM_REQ    operand B of requester i at [4i+:4]
//   req_ready   out  NUM_REQ      one-hot grant; valid only in IDLE
//   resp_valid  out  1            result available
//   resp_id     out  ID_W         requester that owns the result
//   resp_data   out  8            product a*b
//   resp_ready  in   1            consumer accepts the result
//   busy        out  1            FSM is not in IDLE
//   op_count    out  CNT_W        completed responses, wraps silently
// ============================================================================

// ----------------------------------------------------------------------------
// combo_mult: purely combinational unsigned 4x4 multiplier.
//   i_a, i_b  in   4   operands
//   o_p       out  8   product (15*15 = 225 fits, so no overflow)
// ----------------------------------------------------------------------------
module combo_mult (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [7:0] o_p
);
    assign o_p = {4'b0000, i_a} * {4'b0000, i_b};
endmodule

module mult_rr_sched #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [4*NUM_REQ-1:0] req_a,
    input  logic [4*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 resp_valid,
    output logic [ID_W-1:0]      resp_id,
    output logic [7:0]           resp_data,
    input  logic                 resp_ready,
    output logic                 busy,
    output logic [CNT_W-1:0]     op_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t             r_state;
    logic [3:0]         r_a;
    logic [3:0]         r_b;
    logic [ID_W-1:0]    r_id;
    logic [7:0]         r_prod;
    logic [ID_W-1:0]    r_last_grant;
    logic               r_resp_valid;
    logic               r_busy;
    logic [CNT_W-1:0]   r_op_count;

    // ------------------------------------------------------------------------
    // Round-robin candidate ordering.
    // Candidate gi is requester (last_grant + 1 + gi) mod NUM_REQ, so
    // candidate 0 is the highest-priority slot for this arbitration round.
    // The sum needs one extra bit: its maximum is 2*NUM_REQ-1.
    // ------------------------------------------------------------------------
    logic [ID_W:0]      w_sum       [NUM_REQ];
    logic [ID_W-1:0]    w_cand      [NUM_REQ];
    logic [NUM_REQ-1:0] w_cand_valid;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign w_sum[gi]  = {1'b0, r_last_grant} + (ID_W+1)'(gi + 1);
            assign w_cand[gi] = (w_sum[gi] >= (ID_W+1)'(NUM_REQ))
                              ? ID_W'(w_sum[gi] - (ID_W+1)'(NUM_REQ))
                              : w_sum[gi][ID_W-1:0];
            assign w_cand_valid[gi] = req_valid[w_cand[gi]];
        end
    endgenerate

    // First asserted candidate wins; scanning downward lets the lowest
    // candidate index overwrite the others.
    logic            w_any;
    logic [ID_W-1:0] w_winner;

    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_cand_valid[k]) begin
                w_any    = 1'b1;
                w_winner = w_cand[k];
            end
        end
    end

    // Grant is offered only in IDLE. Because the winner is by construction a
    // valid requester, offering a grant is the same as accepting it.
    logic w_accept;
    assign w_accept  = (r_state == S_IDLE) && w_any;
    assign req_ready = w_accept ? (NUM_REQ'(1) << w_winner) : '0;

    // Operand selection for the winning requester.
    logic [3:0] w_sel_a;
    logic [3:0] w_sel_b;
    assign w_sel_a = req_a[w_winner*4 +: 4];
    assign w_sel_b = req_b[w_winner*4 +: 4];

    // ------------------------------------------------------------------------
    // Shared multiplier: fed from registered operands, captured into r_prod.
    // ------------------------------------------------------------------------
    logic [7:0] w_prod;

    combo_mult u_mult (
        .i_a (r_a),
        .i_b (r_b),
        .o_p (w_prod)
    );

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs (resp_valid, busy).
    // A reset at any point drops the in-flight operation: the state returns to
    // IDLE and the counter is cleared, so no response is ever produced for it.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_id         <= '0;
            r_prod       <= '0;
            r_last_grant <= ID_W'(NUM_REQ - 1);
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_op_count   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a          <= w_sel_a;
                        r_b          <= w_sel_b;
                        r_id         <= w_winner;
                        r_last_grant <= w_winner;
                        r_busy       <= 1'b1;
                        r_state      <= S_MUL;
                    end
                end
                S_MUL: begin
                    r_prod       <= w_prod;
                    r_resp_valid <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    // Outputs hold while the consumer stalls; nothing else
                    // is accepted until the response retires.
                    if (resp_ready) begin
                        r_op_count   <= r_op_count + CNT_W'(1);
                        r_resp_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_id    = r_id;
    assign resp_data  = r_prod;
    assign busy       = r_busy;
    assign op_count   = r_op_count;

endmodule

// File: tb/tb_mult_rr_sched.sv
// ============================================================================
// tb_mult_rr_sched
// Directed bench for mult_rr_sched. Expected responses are pushed into a
// scoreboard queue when a grant is observed and popped when the DUT presents
// a response. A second, narrow instance (NUM_REQ=2, CNT_W=3) is used to walk
// the completion counter through its wrap point in a few dozen cycles.
// ============================================================================
module tb_mult_rr_sched;

    // ---------------- main DUT (NUM_REQ=4, CNT_W=16) ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_ready;
    logic        resp_valid;
    logic [1:0]  resp_id;
    logic [7:0]  resp_data;
    logic        resp_ready;
    logic        busy;
    logic [15:0] op_count;

    // ---------------- wrap DUT (NUM_REQ=2, CNT_W=3) -----------------
    logic [1:0]  req_valid2;
    logic [7:0]  req_a2;
    logic [7:0]  req_b2;
    logic [1:0]  req_ready2;
    logic        resp_valid2;
    logic [0:0]  resp_id2;
    logic [7:0]  resp_data2;
    logic        resp_ready2;
    logic        busy2;
    logic [2:0]  op_count2;

    always #5 clk = ~clk;

    mult_rr_sched #(.NUM_REQ(4), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_ready (resp_ready),
        .busy       (busy),
        .op_count   (op_count)
    );

    mult_rr_sched #(.NUM_REQ(2), .CNT_W(3)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid2),
        .req_a      (req_a2),
        .req_b      (req_b2),
        .req_ready  (req_ready2),
        .resp_valid (resp_valid2),
        .resp_id    (resp_id2),
        .resp_data  (resp_data2),
        .resp_ready (resp_ready2),
        .busy       (busy2),
        .op_count   (op_count2)
    );

    // ---------------- scoreboard & counters ----------------
    typedef struct {
        int id;
        int data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // at that same point, well away from the next active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Set operands of requester id inside the packed operand buses.
    task automatic set_ops(input int id, input int a, input int b);
        req_a[id*4 +: 4] = 4'(a);
        req_b[id*4 +: 4] = 4'(b);
    endtask

    // Compare the presented response with the oldest scoreboard entry.
    task automatic pop_and_check(input string tag);
        exp_t e;
        check({tag, "_valid"}, 32'(resp_valid), 32'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_id"},   32'(resp_id),   32'(e.id));
            check({tag, "_data"}, 32'(resp_data), 32'(e.data));
        end
        $display("resp %s id=%0d data=%0d op_count=%0d", tag, resp_id,
                 resp_data, op_count);
    endtask

    // One isolated operation: grant check, 2-edge latency, retire.
    task automatic single_op(input string tag, input int id, input int a,
                             input int b, input int exp_cnt);
        exp_t e;
        set_ops(id, a, b);
        req_valid = 4'(1 << id);
        #1;
        check({tag, "_grant"}, 32'(req_ready), 32'(1 << id));
        e.id = id; e.data = a * b;
        sb.push_back(e);
        tick();                                // accept edge
        req_valid = '0;
        check({tag, "_busy"},       32'(busy),       32'd1);
        check({tag, "_mul_nvalid"}, 32'(resp_valid), 32'd0);
        tick();                                // MUL edge -> RESP
        pop_and_check(tag);
        resp_ready = 1'b1;
        tick();                                // retire edge
        resp_ready = 1'b0;
        check({tag, "_idle_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_idle_busy"},  32'(busy),       32'd0);
        check({tag, "_op_count"},   32'(op_count),   32'(exp_cnt));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int order [5];
        int cnt_before;
        int k;
        exp_t e;

        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        req_valid2 = '0;
        req_a2     = {4'd3, 4'd2};
        req_b2     = {4'd5, 4'd4};
        resp_ready2 = 1'b0;

        // ---- reset state ----
        do_reset();
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_id",    32'(resp_id),    32'd0);
        check("rst_resp_data",  32'(resp_data),  32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_op_count",   32'(op_count),   32'd0);
        check("rst_req_ready",  32'(req_ready),  32'd0);

        // ---- 1) single op 3*5 on req0 ----
        single_op("t1", 0, 3, 5, 1);

        // ---- 2) max operands on req2 ----
        single_op("t2", 2, 15, 15, 2);

        // ---- 3) all four valid continuously: order 0,1,2,3,0 ----
        do_reset();
        set_ops(0, 2, 7);
        set_ops(1, 3, 9);
        set_ops(2, 11, 4);
        set_ops(3, 13, 14);
        order = '{0, 1, 2, 3, 0};
        req_valid  = 4'b1111;
        resp_ready = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3_grant%0d", i), 32'(req_ready),
                  32'(1 << order[i]));
            e.id = order[i];
            e.data = int'(req_a[order[i]*4 +: 4]) * int'(req_b[order[i]*4 +: 4]);
            sb.push_back(e);
            tick();                            // accept
            check($sformatf("t3_mul_ready%0d", i), 32'(req_ready), 32'd0);
            tick();                            // RESP
            check($sformatf("t3_resp_ready%0d", i), 32'(req_ready), 32'd0);
            pop_and_check($sformatf("t3_op%0d", i));
            tick();                            // retire -> IDLE
        end
        check("t3_op_count", 32'(op_count), 32'd5);
        resp_ready = 1'b0;

        // ---- 4) backpressure on a req1 response ----
        // Last grant was 0, so requester 1 wins with everyone still valid.
        set_ops(1, 9, 6);
        #1;
        check("t4_grant", 32'(req_ready), 32'b0010);
        e.id = 1; e.data = 54;
        sb.push_back(e);
        cnt_before = int'(op_count);
        tick();
        tick();
        pop_and_check("t4");
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t4_hold_valid%0d", i), 32'(resp_valid), 32'd1);
            check($sformatf("t4_hold_data%0d", i),  32'(resp_data),  32'd54);
            check($sformatf("t4_hold_id%0d", i),    32'(resp_id),    32'd1);
            check($sformatf("t4_hold_ready%0d", i), 32'(req_ready),  32'd0);
            check($sformatf("t4_hold_cnt%0d", i),   32'(op_count),
                  32'(cnt_before));
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("t4_release_busy",  32'(busy),       32'd0);
        check("t4_release_valid", 32'(resp_valid), 32'd0);
        check("t4_release_cnt",   32'(op_count),   32'(cnt_before + 1));

        // ---- 5) reset while in MUL drops the op ----
        set_ops(0, 7, 7);
        req_valid = 4'b0001;
        tick();                                // accept -> MUL
        req_valid = '0;
        check("t5_in_mul_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_busy",       32'(busy),       32'd0);
        check("t5_resp_valid", 32'(resp_valid), 32'd0);
        check("t5_op_count",   32'(op_count),   32'd0);
        resp_ready = 1'b1;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (resp_valid) k++;
        end
        resp_ready = 1'b0;
        check("t5_never_delivered", 32'(k), 32'd0);
        check("t5_sb_empty", 32'(sb.size()), 32'd0);

        // ---- 6) counter wrap on the narrow instance (CNT_W=3) ----
        req_valid2  = 2'b11;
        resp_ready2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();                            // accept
            tick();                            // RESP
            check($sformatf("t6_id%0d", i), 32'(resp_id2), 32'(i % 2));
            check($sformatf("t6_data%0d", i), 32'(resp_data2),
                  (i % 2 == 0) ? 32'd8 : 32'd15);
            tick();                            // retire
            check($sformatf("t6_cnt%0d", i), 32'(op_count2), 32'((i + 1) % 8));
            $display("wrap op %0d op_count2=%0d", i, op_count2);
        end
        req_valid2  = '0;
        resp_ready2 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish, observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
